// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned DMEM_DEPTH_DEF = 64;
  localparam int unsigned DMEM_WAIT_DEF  = 2;

  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, combinational read, never cleared by reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
  parameter int unsigned AW    = idx_width(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency single-outstanding data-memory responder.
// Optional DMEM_ALIGN_CHECK_EN flags misaligned/out-of-range accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = DMEM_DEPTH_DEF,
  parameter int unsigned WAIT_CYCLES = DMEM_WAIT_DEF
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam int unsigned AW = idx_width(DEPTH);

  state_t        state;
  logic [3:0]    cnt;
  logic          lat_wr;
  logic          lat_err;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_we;
  logic          addr_err;

`ifdef DMEM_ALIGN_CHECK_EN
  assign addr_err = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH * 4));
`else
  // Byte offset and upper bits are dropped so addresses alias modulo DEPTH.
  logic addr_unused;
  assign addr_err    = 1'b0;
  assign addr_unused = ^{req_addr[31:AW+2], req_addr[1:0]};
`endif

  // Gated by state so a reset during WAIT can never let a pending store land.
  assign mem_we = (state == WAIT) && (cnt == '0) && lat_wr && !lat_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (lat_idx),
    .wdata (lat_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_wr     <= 1'b0;
      lat_err    <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            lat_wr    <= req_wr;
            lat_err   <= addr_err;
            lat_idx   <= req_addr[AW+1:2];
            lat_wdata <= req_wdata;
            cnt       <= 4'(WAIT_CYCLES);
            state     <= WAIT;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= lat_err;
            resp_rdata <= (lat_wr || lat_err) ? '0 : mem_rdata;
          end
        end
        RESP: begin
          if (resp_valid && resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            req_ready  <= 1'b1;
            busy       <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2 and 0 instances).
module tb_dmem_responder;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        Reset = 1'b0;
  logic        req_valid = 1'b0, req_wr = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        req_valid_z = 1'b0, req_wr_z = 1'b0, resp_ready_z = 1'b0;
  logic [31:0] req_addr_z = '0, req_wdata_z = '0;
  logic        req_ready_z, resp_valid_z, resp_err_z, busy_z;
  logic [31:0] resp_rdata_z;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut_z (
    .clk(clk), .Reset(Reset),
    .req_valid(req_valid_z), .req_ready(req_ready_z), .req_wr(req_wr_z),
    .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .resp_valid(resp_valid_z), .resp_ready(resp_ready_z),
    .resp_rdata(resp_rdata_z), .resp_err(resp_err_z), .busy(busy_z)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit hold);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rdata,
                      input logic exp_err, input int stall, input bit hold);
    int lat = 0;
    send(tag, wr, addr, wdata, hold);
    chk({tag, "_busy"}, busy, 1);
    while (!resp_valid && lat < 40) begin
      chk({tag, "_wait_rdata"}, resp_rdata, 0);
      @(posedge clk); #1; lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(W + 1));
    chk({tag, "_rdata"}, resp_rdata, exp_rdata);
    chk({tag, "_err"}, resp_err, exp_err);
    for (int i = 0; i < stall; i++) begin
      chk({tag, "_hold_rdata"}, resp_rdata, exp_rdata);
      chk({tag, "_hold_valid"}, resp_valid, 1);
      chk({tag, "_hold_ready"}, req_ready, 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, "_done_valid"}, resp_valid, 0);
    chk({tag, "_done_ready"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc[2];
    int rsp[2];
    logic [31:0] rd[2];
    int na, nr;
    bit will_acc;

    // Reset state
    #3;
    chk("rst_valid", resp_valid, 0);
    chk("rst_rdata", resp_rdata, 0);
    chk("rst_err", resp_err, 0);
    chk("rst_busy", busy, 0);
    #9 Reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", req_ready, 1);
    chk("rel_busy", busy, 0);

    // Store then load
    xfer("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0, 1'b0);
    xfer("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);

    // Stalled response with request still asserted
    xfer("stall", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5, 1'b1);
    @(posedge clk); #1;
    chk("stall_no_reaccept", busy, 0);

    // Reset during WAIT abandons the store
    send("rstw", 1'b1, 32'h10, 32'h12345678, 1'b0);
    chk("rstw_busy", busy, 1);
    @(posedge clk); #1;
    Reset = 1'b0;
    #1;
    chk("rstw_valid", resp_valid, 0);
    chk("rstw_rdata", resp_rdata, 0);
    chk("rstw_err", resp_err, 0);
    chk("rstw_busy0", busy, 0);
    @(posedge clk); @(posedge clk); #2;
    Reset = 1'b1;
    @(posedge clk); #1;
    xfer("ld_after_rst", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);

`ifdef DMEM_ALIGN_CHECK_EN
    xfer("ld13", 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, 0, 1'b0);
    xfer("st0", 1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0, 0, 1'b0);
    xfer("st100", 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b1, 0, 1'b0);
    xfer("ld0", 1'b0, 32'h0, 32'h0, 32'h11111111, 1'b0, 0, 1'b0);
`else
    xfer("ld13", 1'b0, 32'h13, 32'h0, 32'hDEADBEEF, 1'b0, 0, 1'b0);
    xfer("st0", 1'b1, 32'h0, 32'h11111111, 32'h0, 1'b0, 0, 1'b0);
    xfer("st100", 1'b1, 32'h100, 32'hA5A5A5A5, 32'h0, 1'b0, 0, 1'b0);
    xfer("ld0", 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 0, 1'b0);
`endif

    // Zero wait states, back-to-back with resp_ready tied high
    acc = '{0, 0};
    rsp = '{-100, -100};
    rd  = '{32'hFFFFFFFF, 32'hFFFFFFFF};
    na = 0; nr = 0;
    resp_ready_z = 1'b1;
    req_valid_z = 1'b1; req_wr_z = 1'b1; req_addr_z = 32'h4; req_wdata_z = 32'hCAFEF00D;
    for (int e = 1; e <= 12; e++) begin
      will_acc = req_valid_z && req_ready_z;
      @(posedge clk); #1;
      if (will_acc && na < 2) begin
        acc[na] = e;
        na++;
        if (na == 1) begin
          req_wr_z = 1'b0; req_wdata_z = '0;
        end else begin
          req_valid_z = 1'b0;
        end
      end
      if (resp_valid_z && nr < 2) begin
        rsp[nr] = e;
        rd[nr] = resp_rdata_z;
        nr++;
      end
    end
    chk("z_accepts", 32'(na), 2);
    chk("z_resps", 32'(nr), 2);
    chk("z_spacing", 32'(acc[1] - acc[0]), 3);
    chk("z_lat_st", 32'(rsp[0] - acc[0]), 1);
    chk("z_lat_ld", 32'(rsp[1] - acc[1]), 1);
    chk("z_st_rdata", rd[0], 32'h0);
    chk("z_ld_rdata", rd[1], 32'hCAFEF00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored (power of two, 4..1024).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait states per access (0..15).
REQ-003 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 The block SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-007 The block SHALL have port req_wr  input  1  1 = store, 0 = load.
REQ-008 The block SHALL have port req_addr  input  32  byte address.
REQ-009 The block SHALL have port req_wdata  input  32  store data.
REQ-010 The block SHALL have port resp_valid  output  1  response available.
REQ-011 The block SHALL have port resp_ready  input  1  initiator takes the response.
REQ-012 The block SHALL have port resp_rdata  output  32  load data; 0 for stores.
REQ-013 The block SHALL have port resp_err  output  1  access error flag.
REQ-014 The block SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 IDLE: on the edge where req_valid&&req_ready, the block SHALL latch req_wr/addr/wdata, load the counter with WAIT_CYCLES and go to WAIT.
REQ-017 WAIT: while the counter is nonzero the block SHALL decrement it each edge; on the edge with counter==0 it SHALL perform the access and go to RESP.
REQ-018 Latency SHALL be fixed: accept at edge k -> resp_valid high immediately after edge k+WAIT_CYCLES+1.
REQ-019 A store SHALL update the word at index req_addr[log2(DEPTH)+1:2] on the WAIT->RESP edge; a load SHALL capture that word on the same edge.
REQ-020 RESP: resp_valid, resp_rdata and resp_err SHALL stay stable until resp_valid&&resp_ready; on that edge the block SHALL return to IDLE.
REQ-021 Requests presented outside IDLE SHALL be ignored (not queued); the minimum accept-to-accept spacing SHALL be WAIT_CYCLES+3 edges.
REQ-022 A load from an address written by the immediately preceding store SHALL return the stored data.
REQ-023 In IDLE and WAIT, resp_valid, resp_rdata and resp_err SHALL be 0.

Reset
REQ-024 Reset low SHALL immediately force IDLE, counter 0, resp_valid 0, resp_rdata 0, resp_err 0, busy 0; req_ready SHALL be 1 after Reset is released.
REQ-025 Reset during WAIT SHALL abandon the transaction; a pending store SHALL NOT modify memory.
REQ-026 Memory contents SHALL NOT be cleared by Reset.

Configuration
REQ-027 With DMEM_ALIGN_CHECK_EN defined, an access with req_addr[1:0]!=0 or req_addr>=DEPTH*4 SHALL complete with normal latency, resp_err=1, resp_rdata=0 and no memory write.
REQ-028 Without DMEM_ALIGN_CHECK_EN, resp_err SHALL be constant 0, addr[1:0] SHALL be ignored and upper address bits SHALL wrap (alias).

Structure
REQ-029 Package dmem_pkg SHALL hold the state enum, the default DEPTH/WAIT_CYCLES constants and the word-index width function.
REQ-030 Storage SHALL be a sub-module dmem_array (synchronous write, combinational read); FSM and counter SHALL live in dmem_responder.

Verification (DEPTH=64, WAIT_CYCLES=2 unless stated)
REQ-031 Store 0xDEADBEEF to 0x10, then load 0x10 -> rdata 0xDEADBEEF, resp_valid rises 3 edges after each accept, resp_err 0.
REQ-032 Load 0x10 with resp_ready held 0 for 5 cycles and req_valid held 1 -> resp_valid/rdata stable, req_ready 0, no second access until the handshake.
REQ-033 Store 0x12345678 to 0x10, Reset pulsed low in WAIT -> outputs zero at once; a subsequent load of 0x10 returns 0xDEADBEEF.
REQ-034 Load 0x13: with the macro -> resp_err 1, rdata 0; without it -> rdata equals the word at 0x10.
REQ-035 Store 0xA5A5A5A5 to 0x100: without the macro -> a load of 0x0 returns 0xA5A5A5A5; with it -> resp_err 1 and word 0x0 unchanged.
REQ-036 WAIT_CYCLES=0: store then load of 0x4 -> resp_valid one edge after each accept; back-to-back accepts 3 edges apart with resp_ready tied 1.
